// File: rtl/jam_pkg.sv
// Constants and state type shared by JAM and its cost-table responder.
package jam_pkg;

    localparam int N_JOB       = 8;
    localparam int IDX_W       = 3;
    localparam int COST_W      = 7;
    localparam int TBL_DEPTH   = 64;
    localparam int MIN_COST_W  = 10;
    localparam int MATCH_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_e;

endpackage

// File: rtl/jam_cost_rom_if.sv
// Load stream plus JAM request/response signals of the cost table.
interface jam_cost_rom_if;
    import jam_pkg::*;

    logic              load_start;
    logic              load_valid;
    logic [COST_W-1:0] load_data;
    logic              load_ready;
    logic              table_ready;
    logic [IDX_W-1:0]  W;
    logic [IDX_W-1:0]  J;
    logic [COST_W-1:0] Cost;

    modport master (
        output load_start, load_valid, load_data, W, J,
        input  load_ready, table_ready, Cost
    );

    modport slave (
        input  load_start, load_valid, load_data, W, J,
        output load_ready, table_ready, Cost
    );

endinterface

// File: rtl/jam_cost_mem.sv
// Cost register file: one synchronous write port, one registered read port
// whose output is forced to zero when rd_zero is set.
module jam_cost_mem
    import jam_pkg::*;
#(
    parameter int DEPTH = TBL_DEPTH,
    parameter int WIDTH = COST_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    input  logic             rd_zero,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
        rdata_d = rd_zero ? '0 : mem_q[raddr];
    end

    // The whole table must clear on reset, so this stays a flop array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/jam_cost_rom.sv
// JAM cost-table responder: streams in the 8x8 cost matrix, then answers
// every (W, J) request with a registered cost one cycle later.
module jam_cost_rom #(
    parameter int N      = jam_pkg::N_JOB,
    parameter int COST_W = jam_pkg::COST_W
) (
    input  logic         CLK,
    input  logic         RST_n,
    jam_cost_rom_if.slave bus
);
    import jam_pkg::*;

    localparam int DEPTH = N * N;
    localparam int AW    = $clog2(DEPTH);

    state_e        state_q;
    state_e        state_d;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] idx_d;
    logic          we;
    logic          load_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        we         = 1'b0;
        load_ready = 1'b0;
        // load_start always wins: any entry offered alongside it is dropped.
        if (bus.load_start) begin
            idx_d   = '0;
            state_d = LOAD;
        end else if (state_q == LOAD) begin
            load_ready = 1'b1;
            if (bus.load_valid) begin
                we    = 1'b1;
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.load_ready  = load_ready;
    assign bus.table_ready = (state_q == READY);

    jam_cost_mem #(
        .DEPTH (DEPTH),
        .WIDTH (COST_W)
    ) u_mem (
        .clk     (CLK),
        .rst_n   (RST_n),
        .we      (we),
        .waddr   (idx_q),
        .wdata   (bus.load_data),
        .raddr   ({bus.W, bus.J}),
        .rd_zero (state_q != READY),
        .rdata   (bus.Cost)
    );

endmodule
